// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder
//   Frames the byte stream coming out of the UART receiver into robot command
//   packets: START, ID, M0, M1, M2, M3, KICK, CHK, where CHK is the XOR of
//   ID through KICK. A good frame addressed to this robot (or to the broadcast
//   ID 8'hFF) updates the motor/kick outputs and raises cmd_valid for one
//   cycle. A bad checksum or an inter-byte timeout raises chk_err for one
//   cycle and bumps a saturating error counter.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_data    received byte, meaningful on the first cycle of rx_done only
//   rx_done    byte-ready level from the UART (high for about two cycles)
//   motor0..3  signed motor speed commands, held until the next good frame
//   kick       kicker command, held until the next good frame
//   cmd_valid  one-cycle pulse: motor0..3/kick were just updated
//   chk_err    one-cycle pulse: frame dropped (bad checksum or timeout)
//   err_count  saturating count of chk_err pulses
`timescale 1ns/1ps
module rx_cmd_decoder #(
  parameter logic [7:0] START_BYTE     = 8'hAA,
  parameter logic [7:0] BOT_ID         = 8'h03,
  parameter int         TIMEOUT_CYCLES = 8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic signed [7:0] motor0,
  output logic signed [7:0] motor1,
  output logic signed [7:0] motor2,
  output logic signed [7:0] motor3,
  output logic [7:0]        kick,
  output logic              cmd_valid,
  output logic              chk_err,
  output logic [7:0]        err_count
);

  localparam int                GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        BCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_START,
    GET_ID,
    GET_PAY,
    GET_CHK
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             rx_done_q;
  logic             stb;
  logic [7:0]       id_q;
  logic [7:0]       chk_acc;
  logic [2:0]       idx;
  // Payload shift register: after five bytes, [39:32] holds M0 and [7:0] KICK.
  logic [39:0]      pay_sr;
  logic [GAP_W-1:0] gap;

  logic             id_ok;
  logic             timeout;
  logic             load_cmd;
  logic             drop_err;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // UART holds rx_done for more than one cycle; only its rising edge is a byte.
  assign stb   = rx_done & ~rx_done_q;
  assign id_ok = (id_q == BOT_ID) || (id_q == BCAST_ID);

  // A byte arriving on the terminal-count cycle takes priority over timeout.
  assign timeout = (state != WAIT_START) && !stb && (gap == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_START;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    drop_err  = 1'b0;
    case (state)
      WAIT_START: begin
        if (stb && (rx_data == START_BYTE)) begin
          state_nxt = GET_ID;
        end
      end
      GET_ID: begin
        if (stb) begin
          state_nxt = GET_PAY;
        end
      end
      GET_PAY: begin
        if (stb && (idx == 3'd4)) begin
          state_nxt = GET_CHK;
        end
      end
      GET_CHK: begin
        if (stb) begin
          state_nxt = WAIT_START;
          if (rx_data == chk_acc) begin
            // Good frame for another robot is dropped without any pulse.
            load_cmd = id_ok;
          end else begin
            drop_err = 1'b1;
          end
        end
      end
      default: state_nxt = WAIT_START;
    endcase
    if (timeout) begin
      state_nxt = WAIT_START;
      drop_err  = 1'b1;
    end
  end

  // Byte capture, checksum accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_done_q <= 1'b0;
      id_q      <= '0;
      chk_acc   <= '0;
      idx       <= '0;
      pay_sr    <= '0;
      gap       <= '0;
      motor0    <= '0;
      motor1    <= '0;
      motor2    <= '0;
      motor3    <= '0;
      kick      <= '0;
      cmd_valid <= 1'b0;
      chk_err   <= 1'b0;
      err_count <= '0;
    end else begin
      rx_done_q <= rx_done;

      if ((state == WAIT_START) || stb || timeout) begin
        gap <= '0;
      end else begin
        gap <= gap + GAP_W'(1);
      end

      if (stb && (state == GET_ID)) begin
        id_q    <= rx_data;
        chk_acc <= rx_data;
        idx     <= '0;
      end

      if (stb && (state == GET_PAY)) begin
        pay_sr  <= {pay_sr[31:0], rx_data};
        chk_acc <= chk_acc ^ rx_data;
        idx     <= idx + 3'd1;
      end

      cmd_valid <= load_cmd;
      chk_err   <= drop_err;

      if (load_cmd) begin
        motor0 <= $signed(pay_sr[39:32]);
        motor1 <= $signed(pay_sr[31:24]);
        motor2 <= $signed(pay_sr[23:16]);
        motor3 <= $signed(pay_sr[15:8]);
        kick   <= pay_sr[7:0];
      end

      if (drop_err) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
`timescale 1ns/1ps
module tb_rx_cmd_decoder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_done = 1'b0;
  logic signed [7:0] motor0, motor1, motor2, motor3;
  logic [7:0]        kick;
  logic              cmd_valid;
  logic              chk_err;
  logic [7:0]        err_count;

  rx_cmd_decoder #(
    .START_BYTE    (8'hAA),
    .BOT_ID        (8'h03),
    .TIMEOUT_CYCLES(8000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .motor0   (motor0),
    .motor1   (motor1),
    .motor2   (motor2),
    .motor3   (motor3),
    .kick     (kick),
    .cmd_valid(cmd_valid),
    .chk_err  (chk_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] m0, m1, m2, m3, k, ec;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t got;
  exp_t none;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit is_err, input logic [7:0] m0, m1, m2, m3, k, ec);
    exp_t e;
    e.is_err = is_err;
    e.m0 = m0; e.m1 = m1; e.m2 = m2; e.m3 = m3; e.k = k; e.ec = ec;
    e.cyc = 0;
    return e;
  endfunction

  // One UART byte: rx_done high for 'hold' cycles, data valid on the first only.
  // When push is set, an output event is expected 'lat' cycles after the strobe.
  task automatic send_byte(input logic [7:0] b, input int hold, input bit push,
                           input int lat, input exp_t e);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    if (push) begin
      e.cyc = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    rx_data = 8'h00;
    repeat (hold - 1) @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f [8], input int hold, input bit push, input exp_t e);
    for (int i = 0; i < 8; i++) begin
      send_byte(f[i], hold, push && (i == 7), 1, e);
    end
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (cmd_valid || chk_err)) begin
      check("pulse_overlap", {31'b0, cmd_valid & chk_err}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'b0, cmd_valid, chk_err}, 32'd0);
      end else begin
        got = q.pop_front();
        check("pulse_cycle", cyc, got.cyc);
        check("chk_err_kind", {31'b0, chk_err}, {31'b0, got.is_err});
        check("cmd_valid_kind", {31'b0, cmd_valid}, {31'b0, !got.is_err});
        check("motor0", {24'h0, motor0}, {24'h0, got.m0});
        check("motor1", {24'h0, motor1}, {24'h0, got.m1});
        check("motor2", {24'h0, motor2}, {24'h0, got.m2});
        check("motor3", {24'h0, motor3}, {24'h0, got.m3});
        check("kick", {24'h0, kick}, {24'h0, got.k});
        check("err_count", {24'h0, err_count}, {24'h0, got.ec});
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      check("missing_pulse", {31'b0, cmd_valid | chk_err}, 32'd1);
      void'(q.pop_front());
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1 [8];
    logic [7:0] f2 [8];
    logic [7:0] fbad [8];
    logic [7:0] f7 [8];
    logic [7:0] junk [10];
    f1   = '{8'hAA, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h43};
    f2   = '{8'hAA, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFE};
    fbad = '{8'hAA, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h44};
    f7   = '{8'hAA, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h16};
    junk = '{8'h55, 8'hAA, 8'hAA, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h43};
    none = mk(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_motor0", {24'h0, motor0}, 32'h0);
    check("rst_motor1", {24'h0, motor1}, 32'h0);
    check("rst_motor2", {24'h0, motor2}, 32'h0);
    check("rst_motor3", {24'h0, motor3}, 32'h0);
    check("rst_kick", {24'h0, kick}, 32'h0);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    check("rst_chk_err", {31'b0, chk_err}, 32'h0);
    check("rst_err_count", {24'h0, err_count}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Own-ID frame
    send_frame(f1, 2, 1'b1, mk(0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'd0));
    // Broadcast frame, rx_done held 4 cycles per byte
    send_frame(f2, 4, 1'b1, mk(0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'd0));
    // Bad checksum: outputs keep previous values
    send_frame(fbad, 2, 1'b1, mk(1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'd1));
    // Foreign ID with valid checksum: silent
    send_frame(f7, 2, 1'b0, none);
    // Leading junk, then AA AA: second AA taken as ID, frame fails checksum on 00
    for (int i = 0; i < 10; i++) begin
      send_byte(junk[i], 2, i == 8, 1, mk(1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'd2));
    end
    send_frame(f1, 2, 1'b1, mk(0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'd2));

    // Inter-byte timeout after byte M0
    send_byte(8'hAA, 2, 1'b0, 1, none);
    send_byte(8'h03, 2, 1'b0, 1, none);
    send_byte(8'h10, 2, 1'b1, 8001, mk(1, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'd3));
    repeat (8050) @(posedge clk);
    send_frame(f1, 2, 1'b1, mk(0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'd3));

    // Reset mid-frame after M1
    send_byte(8'hAA, 2, 1'b0, 1, none);
    send_byte(8'h03, 2, 1'b0, 1, none);
    send_byte(8'h10, 2, 1'b0, 1, none);
    send_byte(8'h20, 2, 1'b0, 1, none);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_motor0", {24'h0, motor0}, 32'h0);
    check("midrst_motor3", {24'h0, motor3}, 32'h0);
    check("midrst_kick", {24'h0, kick}, 32'h0);
    check("midrst_err_count", {24'h0, err_count}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    send_frame(f1, 2, 1'b1, mk(0, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'd0));

    // Error counter saturation
    for (int i = 1; i <= 300; i++) begin
      send_frame(fbad, 2, 1'b1,
                 mk(1, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00, (i > 255) ? 8'd255 : 8'(i)));
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("final_err_count", {24'h0, err_count}, 32'd255);
    check("queue_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
